// File: rtl/ppu_oam_dma_if.sv
// ============================================================================
// Module      : ppu_oam_dma_if
// Description : Bus bundle between the CPU core, the sprite DMA and the CPU
//               bus address decoder.
//               master : DMA side. It snoops the CPU bus, takes DMA read data,
//                        and drives the CPU ready line and the DMA bus.
//               slave  : CPU/bus side. It is the mirror image of master.
//               Signals:
//                 cpu_a_in/cpu_d_in/cpu_r_nw_in  CPU bus, snooped
//                 mem_d_in                       read data for DMA reads
//                 rdy_out, busy_out              CPU stall / bus ownership
//                 a_out, d_out, r_nw_out         DMA bus drivers
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ppu_oam_dma_if;
  logic [15:0] cpu_a_in;
  logic [7:0]  cpu_d_in;
  logic        cpu_r_nw_in;
  logic [7:0]  mem_d_in;
  logic        rdy_out;
  logic        busy_out;
  logic [15:0] a_out;
  logic [7:0]  d_out;
  logic        r_nw_out;

  modport master (
    input  cpu_a_in, cpu_d_in, cpu_r_nw_in, mem_d_in,
    output rdy_out, busy_out, a_out, d_out, r_nw_out
  );

  modport slave (
    output cpu_a_in, cpu_d_in, cpu_r_nw_in, mem_d_in,
    input  rdy_out, busy_out, a_out, d_out, r_nw_out
  );
endinterface

`default_nettype wire

// File: rtl/ppu_oam_dma.sv
// ============================================================================
// Module      : ppu_oam_dma
// Description : Sprite-attribute DMA. A CPU write to $4014 stalls the CPU.
//               The block then copies page $XX00-$XXFF into the PPU OAM data
//               port ($2004) as 256 read/write pairs, and it owns the CPU bus
//               while busy.
//               Ports:
//                 clk_in    system clock, rising edge
//                 rst_n_in  asynchronous active-low reset
//                 ce_in     CPU bus-cycle enable; state advances only when 1
//                 bus       ppu_oam_dma_if.master (snoop, read data, DMA bus)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ppu_oam_dma (
  input  wire            clk_in,
  input  wire            rst_n_in,
  input  wire            ce_in,
  ppu_oam_dma_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam logic [15:0] C_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] C_OAM_ADDR  = 16'h2004;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_page;
  logic [7:0]  r_cnt;
  logic [7:0]  r_data;
  logic        r_par;      // high on odd CPU cycles; toggles on every ce

  logic        w_trigger;
  logic        w_last;
  logic [15:0] w_a;
  logic [7:0]  w_d;
  logic        w_r_nw;

  // Only a write in IDLE starts a transfer. Snooped writes while busy are
  // ignored.
  assign w_trigger = (r_state == S_IDLE) && !bus.cpu_r_nw_in &&
                     (bus.cpu_a_in == C_TRIG_ADDR);
  assign w_last    = (r_cnt == 8'hFF);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_trigger) w_state_nxt = S_HALT;
      // Reads must land on even cycles. If HALT is already odd, the next
      // cycle is even and the read can follow immediately.
      S_HALT:  w_state_nxt = r_par ? S_READ : S_ALIGN;
      S_ALIGN: w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = w_last ? S_IDLE : S_READ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus drivers decode from registered state only.
  always_comb begin
    w_a    = 16'h0000;
    w_d    = 8'h00;
    w_r_nw = 1'b1;
    case (r_state)
      S_READ: begin
        w_a = {r_page, r_cnt};
      end
      S_WRITE: begin
        w_a    = C_OAM_ADDR;
        w_d    = r_data;
        w_r_nw = 1'b0;
      end
      default: begin
        w_a    = 16'h0000;
        w_d    = 8'h00;
        w_r_nw = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
      r_page  <= 8'h00;
      r_cnt   <= 8'h00;
      r_data  <= 8'h00;
      r_par   <= 1'b0;
    end else if (ce_in) begin
      r_par   <= ~r_par;
      r_state <= w_state_nxt;
      if (w_trigger) begin
        r_page <= bus.cpu_d_in;
        r_cnt  <= 8'h00;
      end
      if (r_state == S_READ) begin
        r_data <= bus.mem_d_in;
      end
      // The counter holds at $FF on the last write, so the address never
      // crosses into the next page.
      if ((r_state == S_WRITE) && !w_last) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign bus.a_out    = w_a;
  assign bus.d_out    = w_d;
  assign bus.r_nw_out = w_r_nw;
  assign bus.busy_out = (r_state != S_IDLE);
  assign bus.rdy_out  = (r_state == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ppu_oam_dma.sv
// ============================================================================
// Module      : tb_ppu_oam_dma
// Description : Scoreboard bench for ppu_oam_dma. Each transfer pushes its
//               expected busy bus cycles into a queue. A negedge monitor pops
//               one entry per busy ce cycle and compares it with the DUT.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ppu_oam_dma;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic ce_in;

  ppu_oam_dma_if bus();

  ppu_oam_dma dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .ce_in    (ce_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  // Memory model: each byte of every page holds (low address byte ^ $A5).
  assign bus.mem_d_in = bus.a_out[7:0] ^ 8'hA5;

  int          checks   = 0;
  int          errors   = 0;
  int          n_writes = 0;
  logic [24:0] exp_q[$];   // {r_nw, addr, data}
  logic        m_par;      // bench model of the odd-cycle flag

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) m_par <= 1'b0;
    else if (ce_in) m_par <= ~m_par;
  end

  // Monitor: sample mid-cycle. Busy ce cycles are checked against the
  // scoreboard. Busy gap cycles must hold the previous outputs.
  logic [24:0] last;
  bit          last_ok = 1'b0;
  always @(negedge clk_in) begin
    logic [24:0] cur;
    logic [24:0] e;
    cur = {bus.r_nw_out, bus.a_out, bus.d_out};
    if (!rst_n_in) begin
      last_ok = 1'b0;
    end else if (ce_in && bus.busy_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_cycle unexpected got rnw=%0b a=%h d=%h, none required",
                 cur[24], cur[23:8], cur[7:0]);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL bus_cycle got rnw=%0b a=%h d=%h required rnw=%0b a=%h d=%h",
                   cur[24], cur[23:8], cur[7:0], e[24], e[23:8], e[7:0]);
        end
        // Data cycles must sit on fixed parity: reads even, writes odd.
        if (e[23:8] != 16'h0000) begin
          checks++;
          if (m_par !== ~e[24]) begin
            errors++;
            $display("FAIL cycle_parity rnw=%0b got par=%0b required par=%0b",
                     e[24], m_par, ~e[24]);
          end
        end
      end
      if (!cur[24]) n_writes++;
      last_ok = 1'b0;
    end else if (!ce_in && bus.busy_out) begin
      if (last_ok) begin
        checks++;
        if (cur !== last) begin
          errors++;
          $display("FAIL gap_stable got %h required %h", cur, last);
        end
      end
      last    = cur;
      last_ok = 1'b1;
    end else begin
      last_ok = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_idle();
    bus.cpu_a_in    = 16'h0000;
    bus.cpu_d_in    = 8'h00;
    bus.cpu_r_nw_in = 1'b1;
  endtask

  // One ce cycle followed by 'gap' cycles with ce low.
  task automatic ce_step(input int gap);
    ce_in = 1'b1;
    tick();
    ce_in = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},  int'(bus.rdy_out),  1);
    check({tag, "_busy"}, int'(bus.busy_out), 0);
    check({tag, "_a"},    int'(bus.a_out),    0);
    check({tag, "_d"},    int'(bus.d_out),    0);
    check({tag, "_rnw"},  int'(bus.r_nw_out), 1);
  endtask

  task automatic run_xfer(input logic [7:0] page, input bit want_par,
                          input int gap, input int abort_after, input bit inject);
    int n;
    int len;
    int pairs;
    int w0;
    bit halt_par;
    logic [7:0] lo;
    if (m_par != want_par) ce_step(0);
    halt_par = ~want_par;
    len      = halt_par ? 513 : 514;
    pairs    = (abort_after != 0) ? abort_after : 256;
    exp_q.push_back({1'b1, 16'h0000, 8'h00});              // HALT
    if (!halt_par) exp_q.push_back({1'b1, 16'h0000, 8'h00}); // ALIGN
    for (int i = 0; i < pairs; i++) begin
      lo = i[7:0];
      exp_q.push_back({1'b1, page, lo, 8'h00});
      exp_q.push_back({1'b0, 16'h2004, lo ^ 8'hA5});
    end
    w0 = n_writes;
    bus.cpu_a_in    = 16'h4014;
    bus.cpu_d_in    = page;
    bus.cpu_r_nw_in = 1'b0;
    ce_step(gap);
    bus_idle();
    n = 0;
    while (bus.busy_out && n < 600) begin
      if (abort_after != 0 && (n_writes - w0) == abort_after) break;
      if (inject && n == 5) begin
        bus.cpu_a_in    = 16'h4014;
        bus.cpu_d_in    = 8'h55;
        bus.cpu_r_nw_in = 1'b0;
      end
      ce_step(gap);
      bus_idle();
      n++;
    end
    if (abort_after != 0) begin
      rst_n_in = 1'b0;
      #1;
      check_reset_outputs("abort");
      check("abort_writes", n_writes - w0, abort_after);
      repeat (4) ce_step(0);
      check("abort_busy", int'(bus.busy_out), 0);
      rst_n_in = 1'b1;
      tick();
    end else begin
      check("xfer_len", n, len);
      check("end_rdy", int'(bus.rdy_out), 1);
      check("end_writes", n_writes - w0, 256);
    end
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in = 1'b0;
    ce_in    = 1'b0;
    bus_idle();
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n_in = 1'b1;
    tick();

    // Even-cycle trigger: HALT lands on an odd cycle.
    run_xfer(8'h02, 1'b0, 0, 0, 1'b0);
    // Odd-cycle trigger: an ALIGN cycle is needed.
    run_xfer(8'h02, 1'b1, 0, 0, 1'b0);
    // Three dead clocks between every ce.
    run_xfer(8'h02, 1'b0, 3, 0, 1'b0);
    // Reset after the 10th write of a $0700 transfer, then a fresh one.
    run_xfer(8'h07, 1'b0, 0, 10, 1'b0);
    run_xfer(8'h03, 1'b0, 0, 0, 1'b0);

    // A read of $4014 must not trigger.
    bus.cpu_a_in    = 16'h4014;
    bus.cpu_d_in    = 8'h09;
    bus.cpu_r_nw_in = 1'b1;
    ce_step(0);
    bus_idle();
    check("read_4014_busy", int'(bus.busy_out), 0);
    check("read_4014_rdy",  int'(bus.rdy_out),  1);

    // Top page, with a snooped $4014 write injected while busy.
    run_xfer(8'hFF, 1'b1, 0, 0, 1'b1);
    repeat (4) ce_step(0);
    check("final_idle_busy", int'(bus.busy_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
